neuron_weight_loader: RTL and testbench



---
 rtl/neuron_weight_loader_pkg.sv | 27 ++
 rtl/neuron_weight_loader_if.sv | 13 +
 rtl/neuron_byte_checksum.sv | 29 ++
 rtl/neuron_weight_loader.sv | 141 ++++++++++++++
 tb/tb_neuron_weight_loader.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/neuron_weight_loader_pkg.sv
// Shared constants for the threshold neuron and its weight loader.
// Optional build macro: NEURON_WEIGHT_LOADER_CHECKSUM_EN adds a trailing
// checksum byte to every frame.
// No ports (package).
package neuron_pkg;

    localparam int unsigned N_INPUTS     = 9;
    localparam int unsigned W_BITS       = 8;
    localparam int unsigned WEIGHT_BYTES = N_INPUTS + 1;
    localparam int unsigned WEIGHTS_W    = WEIGHT_BYTES * W_BITS;

`ifdef NEURON_WEIGHT_LOADER_CHECKSUM_EN
    localparam int unsigned FRAME_BYTES  = N_INPUTS + 2;
`else
    localparam int unsigned FRAME_BYTES  = N_INPUTS + 1;
`endif

    localparam int unsigned IDX_W        = $clog2(FRAME_BYTES + 1);

    // Loader states
    typedef logic [1:0] loader_state_t;
    localparam loader_state_t IDLE   = 2'd0;
    localparam loader_state_t LOAD   = 2'd1;
    localparam loader_state_t COMMIT = 2'd2;
    localparam loader_state_t DRAIN  = 2'd3;

endpackage

// File: rtl/neuron_weight_loader_if.sv
// Byte stream handshake carrying weight frames into the loader.
// Signals: s_data (byte), s_valid, s_last (final byte of frame), s_ready.
interface neuron_weight_loader_if;

    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (output s_data, output s_valid, output s_last, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last, output s_ready);

endinterface

// File: rtl/neuron_byte_checksum.sv
// Running 8-bit sum of frame bytes; sum_ok_c reports whether the sum
// including the byte currently presented on data wraps to zero.
// Ports: clk, rst_n, clr (clear, wins over add), add (accumulate data),
//        data[7:0], sum_ok_c (combinational zero flag).
module neuron_byte_checksum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       add,
    input  logic [7:0] data,
    output logic       sum_ok_c
);

    logic [7:0] sum_q;

    // Accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= 8'h00;
        end else if (clr) begin
            sum_q <= 8'h00;
        end else if (add) begin
            sum_q <= 8'(sum_q + data);
        end
    end

    assign sum_ok_c = (8'(sum_q + data) == 8'h00);

endmodule

// File: rtl/neuron_weight_loader.sv
// Assembles bias + N_INPUTS weight bytes from a byte stream into a shadow
// register and commits it atomically to weights after a well-formed frame.
// Optional build macro: NEURON_WEIGHT_LOADER_CHECKSUM_EN (trailing checksum).
// Ports: clk, rst_n (async active-low), s (stream slave: s_data, s_valid,
//        s_last, s_ready), weights (committed vector, bias in [7:0]),
//        weights_valid (sticky), commit_pulse, frame_err (1-cycle strobes).
module neuron_weight_loader
    import neuron_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    neuron_weight_loader_if.slave s,
    output logic [WEIGHTS_W-1:0] weights,
    output logic                 weights_valid,
    output logic                 commit_pulse,
    output logic                 frame_err
);

    loader_state_t        state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [WEIGHTS_W-1:0] shadow_q, shadow_d;
    logic [WEIGHTS_W-1:0] weights_d;
    logic                 weights_valid_d;
    logic                 commit_d;
    logic                 err_d;
    logic                 ready_q, ready_d;

    logic accept_c;
    logic last_idx_c;
    logic store_c;
    logic sum_ok_c;

    assign s.s_ready  = ready_q;
    assign accept_c   = s.s_valid && ready_q;
    assign last_idx_c = (idx_q == IDX_W'(FRAME_BYTES - 1));
    // Checksum byte (when present) sits past the weight bytes and is not stored
    assign store_c    = (idx_q < IDX_W'(WEIGHT_BYTES));

`ifdef NEURON_WEIGHT_LOADER_CHECKSUM_EN
    logic sum_add_c;
    logic sum_clr_c;

    // Accumulate payload bytes; clear whenever a frame ends or overflows
    assign sum_add_c = accept_c && ((state_q == IDLE) || (state_q == LOAD));
    assign sum_clr_c = sum_add_c && (s.s_last || last_idx_c);

    neuron_byte_checksum u_checksum (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (sum_clr_c),
        .add      (sum_add_c),
        .data     (s.s_data),
        .sum_ok_c (sum_ok_c)
    );
`else
    assign sum_ok_c = 1'b1;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            shadow_q      <= '0;
            weights       <= '0;
            weights_valid <= 1'b0;
            commit_pulse  <= 1'b0;
            frame_err     <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            weights       <= weights_d;
            weights_valid <= weights_valid_d;
            commit_pulse  <= commit_d;
            frame_err     <= err_d;
            ready_q       <= ready_d;
        end
    end

    // Next-state and output decode. The commit is taken on the last-byte
    // handshake so weights and commit_pulse change together one cycle later;
    // COMMIT is then the single bubble cycle with s_ready low.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        shadow_d        = shadow_q;
        weights_d       = weights;
        weights_valid_d = weights_valid;
        commit_d        = 1'b0;
        err_d           = 1'b0;

        case (state_q)
            IDLE, LOAD: begin
                if (accept_c) begin
                    if (store_c) begin
                        shadow_d[32'(idx_q) * W_BITS +: W_BITS] = s.s_data;
                    end
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = LOAD;
                    if (last_idx_c) begin
                        idx_d = '0;
                        if (!s.s_last) begin
                            state_d = DRAIN;
                        end else if (sum_ok_c) begin
                            state_d         = COMMIT;
                            weights_d       = shadow_d;
                            weights_valid_d = 1'b1;
                            commit_d        = 1'b1;
                        end else begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                        end
                    end else if (s.s_last) begin
                        idx_d   = '0;
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            COMMIT: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            DRAIN: begin
                if (accept_c && s.s_last) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            default: begin
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d != COMMIT);
    end

endmodule

// File: tb/tb_neuron_weight_loader.sv
// Randomized self-checking bench for neuron_weight_loader. A frame-level
// model judges each whole frame (length, optional checksum) and predicts
// the committed vector and strobe counts.
module tb_neuron_weight_loader;
    import neuron_pkg::*;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    neuron_weight_loader_if sif();

    logic [WEIGHTS_W-1:0] weights;
    logic                 weights_valid;
    logic                 commit_pulse;
    logic                 frame_err;

    neuron_weight_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s             (sif),
        .weights       (weights),
        .weights_valid (weights_valid),
        .commit_pulse  (commit_pulse),
        .frame_err     (frame_err)
    );

    int n_checks = 0;
    int n_bad    = 0;
    int n_commit = 0;
    int n_err    = 0;
    int n_both   = 0;
    int exp_commit = 0;
    int exp_err    = 0;
    int gap_pct    = 0;
    logic [WEIGHTS_W-1:0] exp_w;
    logic                 exp_wv;

    task automatic check_eq(input string tag, input logic [WEIGHTS_W-1:0] got,
                            input logic [WEIGHTS_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Strobe monitor
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (commit_pulse === 1'b1) n_commit++;
            if (frame_err === 1'b1) n_err++;
            if (commit_pulse === 1'b1 && frame_err === 1'b1) n_both++;
        end
    end

    // Offer one byte until it is accepted, with random valid gaps
    task automatic push_byte(input logic [7:0] b, input logic last);
        bit done = 1'b0;
        for (int k = 0; k < 500 && !done; k++) begin
            @(negedge clk);
            if ($urandom_range(99) < gap_pct) begin
                sif.s_valid = 1'b0;
            end else begin
                sif.s_valid = 1'b1;
                sif.s_data  = b;
                sif.s_last  = last;
                if (sif.s_ready === 1'b1) begin
                    @(posedge clk);
                    done = 1'b1;
                end
            end
        end
        if (!done) check_eq("hs_timeout", WEIGHTS_W'(done), WEIGHTS_W'(1));
    endtask

    // Frame-level reference: accept iff the length is exact (and the byte sum
    // wraps to zero when the checksum build is used)
    function automatic bit frame_ok(input bq_t q);
        bit ok;
        logic [7:0] sum;
        ok  = (q.size() == FRAME_BYTES);
        sum = 8'h00;
        foreach (q[i]) sum = 8'(sum + q[i]);
`ifdef NEURON_WEIGHT_LOADER_CHECKSUM_EN
        ok = ok && (sum == 8'h00);
`endif
        return ok;
    endfunction

    // Append the checksum byte when the build expects one
    function automatic bq_t good_frame(input bq_t p);
        bq_t q;
        logic [7:0] sum;
        q   = p;
        sum = 8'h00;
        foreach (p[i]) sum = 8'(sum + p[i]);
`ifdef NEURON_WEIGHT_LOADER_CHECKSUM_EN
        q.push_back(8'(8'h00 - sum));
`endif
        return q;
    endfunction

    task automatic send_frame(input bq_t q, input string tag);
        bit ok;
        ok = frame_ok(q);
        for (int i = 0; i < q.size(); i++) push_byte(q[i], (i == q.size() - 1));
        if (ok) begin
            exp_commit++;
            exp_wv = 1'b1;
            for (int k = 0; k < WEIGHT_BYTES; k++) exp_w[k*8 +: 8] = q[k];
        end else begin
            exp_err++;
        end
        @(negedge clk);
        sif.s_valid = 1'b0;
        sif.s_last  = 1'b0;
        check_eq({tag, "_commit"}, WEIGHTS_W'(commit_pulse), WEIGHTS_W'(ok));
        check_eq({tag, "_err"}, WEIGHTS_W'(frame_err), WEIGHTS_W'(!ok));
        check_eq({tag, "_weights"}, weights, exp_w);
        check_eq({tag, "_wvalid"}, WEIGHTS_W'(weights_valid), WEIGHTS_W'(exp_wv));
        check_eq({tag, "_ready"}, WEIGHTS_W'(sif.s_ready), WEIGHTS_W'(!ok));
        @(negedge clk);
        check_eq({tag, "_strobe_end"}, WEIGHTS_W'({commit_pulse, frame_err}), '0);
        check_eq({tag, "_ready_back"}, WEIGHTS_W'(sif.s_ready), WEIGHTS_W'(1));
    endtask

    initial begin
        bq_t p;
        bq_t q;
        int  len;

        rst_n       = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_data  = 8'h00;
        sif.s_last  = 1'b0;
        exp_w       = '0;
        exp_wv      = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_weights", weights, '0);
        check_eq("rst_wvalid", WEIGHTS_W'(weights_valid), '0);
        check_eq("rst_ready", WEIGHTS_W'(sif.s_ready), '0);
        check_eq("rst_commit", WEIGHTS_W'(commit_pulse), '0);
        check_eq("rst_err", WEIGHTS_W'(frame_err), '0);
        rst_n = 1'b1;

        // Sequential payload
        p = {};
        for (int i = 1; i <= 10; i++) p.push_back(8'(i));
        send_frame(good_frame(p), "seq");
        check_eq("seq_const", weights, 80'h0A090807060504030201);

        // Too short, then a good descending frame
        send_frame('{8'h11, 8'h22, 8'h33, 8'h44}, "short");
        p = {};
        for (int i = 0; i < 10; i++) p.push_back(8'(8'hFF - i));
        send_frame(good_frame(p), "desc");

        // Too long
        q = {};
        for (int i = 0; i < 12; i++) q.push_back(8'($urandom));
        send_frame(q, "long");

        // Gappy valid
        gap_pct = 50;
        p = {};
        for (int i = 0; i < 10; i++) p.push_back(8'h80);
        send_frame(good_frame(p), "gappy");
        check_eq("gappy_const", weights, {10{8'h80}});
        gap_pct = 0;

        // Reset mid-frame
        for (int i = 0; i < 5; i++) push_byte(8'($urandom), 1'b0);
        @(negedge clk);
        sif.s_valid = 1'b0;
        rst_n       = 1'b0;
        #1;
        check_eq("midrst_weights", weights, '0);
        check_eq("midrst_wvalid", WEIGHTS_W'(weights_valid), '0);
        check_eq("midrst_ready", WEIGHTS_W'(sif.s_ready), '0);
        exp_w  = '0;
        exp_wv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        p = {};
        for (int i = 0; i < 10; i++) p.push_back(8'($urandom));
        send_frame(good_frame(p), "postrst");

`ifdef NEURON_WEIGHT_LOADER_CHECKSUM_EN
        p = {};
        for (int i = 1; i <= 10; i++) p.push_back(8'(i));
        q = p;
        q.push_back(8'hC9);
        send_frame(q, "cks_good");
        q = p;
        q.push_back(8'hC8);
        send_frame(q, "cks_bad");
`endif

        // Random frames
        for (int f = 0; f < 40; f++) begin
            gap_pct = $urandom_range(60);
            if ($urandom_range(1) == 1) len = FRAME_BYTES;
            else len = $urandom_range(FRAME_BYTES + 3, 1);
            q = {};
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            if (len == FRAME_BYTES && $urandom_range(1) == 1) begin
                q.pop_back();
                q = good_frame(q);
`ifndef NEURON_WEIGHT_LOADER_CHECKSUM_EN
                q.push_back(8'($urandom));
`endif
            end
            send_frame(q, $sformatf("rnd%0d", f));
        end
        gap_pct = 0;

        check_eq("commit_count", WEIGHTS_W'(n_commit), WEIGHTS_W'(exp_commit));
        check_eq("err_count", WEIGHTS_W'(n_err), WEIGHTS_W'(exp_err));
        check_eq("both_strobes", WEIGHTS_W'(n_both), '0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
